// File: rtl/serial_word_assembler.sv
// serial_word_assembler
//   Serial-to-parallel front end for a load register. Shifts in a WIDTH-bit
//   word, MSB first, from a qualified bit stream. When PARITY_EN=1, one
//   even-parity bit follows the data bits and is checked. A good frame
//   updates word_out and pulses load_en for one cycle. A frame with bad
//   parity pulses par_err for one cycle and leaves word_out unchanged.
//
// Handshake: a bit is accepted on any rising clk edge where bit_vld=1.
//   sof is only meaningful together with bit_vld. It marks the first data
//   bit and aborts any frame already in progress.
//
// Ports
//   clk       in   1      rising-edge clock
//   rst_n     in   1      synchronous reset, active low
//   bit_vld   in   1      bit_in/sof valid this cycle
//   sof       in   1      start of frame (first data bit)
//   bit_in    in   1      serial data bit
//   word_out  out  WIDTH  last good word, registered
//   load_en   out  1      one-cycle pulse: word_out is new
//   par_err   out  1      one-cycle pulse: frame dropped on parity mismatch
//   busy      out  1      frame in progress (state != IDLE)
//   state_dbg out  2      current FSM state, for observation only
module serial_word_assembler #(
  parameter int WIDTH     = 4,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_vld,
  input  logic             sof,
  input  logic             bit_in,
  output logic [WIDTH-1:0] word_out,
  output logic             load_en,
  output logic             par_err,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    LOAD   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             load_en_q, load_en_d;
  logic             par_err_q, par_err_d;

  // Candidate shift-register/count update for the bit being accepted.
  logic             take;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    acc_cnt;
  logic             start;

  assign start = bit_vld & sof;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    word_d    = word_q;
    load_en_d = 1'b0;
    par_err_d = 1'b0;
    take      = 1'b0;
    acc       = shreg_q;
    acc_cnt   = cnt_q;

    if (start) begin
      // sof always opens a new frame; anything half-assembled is dropped
      // silently, whatever state we are in.
      take    = 1'b1;
      acc     = WIDTH'(bit_in);
      acc_cnt = CW'(1);
    end else begin
      unique case (state_q)
        IDLE, LOAD: state_d = IDLE;
        SHIFT: begin
          if (bit_vld) begin
            take    = 1'b1;
            acc     = (shreg_q << 1) | WIDTH'(bit_in);
            acc_cnt = cnt_q + CW'(1);
          end
        end
        PARITY: begin
          if (bit_vld) begin
            if ((^{shreg_q, bit_in}) == 1'b0) begin
              word_d    = shreg_q;
              load_en_d = 1'b1;
              state_d   = LOAD;
            end else begin
              par_err_d = 1'b1;
              state_d   = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (take) begin
      shreg_d = acc;
      cnt_d   = acc_cnt;
      if (acc_cnt == CNT_FULL) begin
        if (PARITY_EN) begin
          state_d = PARITY;
        end else begin
          // No parity bit: the assembled word is published on entry to LOAD.
          word_d    = acc;
          load_en_d = 1'b1;
          state_d   = LOAD;
        end
      end else begin
        state_d = SHIFT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shreg_q   <= '0;
      word_q    <= '0;
      load_en_q <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      word_q    <= word_d;
      load_en_q <= load_en_d;
      par_err_q <= par_err_d;
    end
  end

  assign word_out  = word_q;
  assign load_en   = load_en_q;
  assign par_err   = par_err_q;
  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_serial_word_assembler.sv
// Bench for serial_word_assembler. Two instances share clk/rst_n:
//   dut_a: WIDTH=4, PARITY_EN=1
//   dut_b: WIDTH=4, PARITY_EN=0
// Expected pulses are queued as {is_par_err, word} when the closing bit is
// driven and popped by a per-instance monitor when a pulse appears.
module tb_serial_word_assembler;

  logic       clk;
  logic       rst_n;
  logic       vld_a, sof_a, bit_a;
  logic       vld_b, sof_b, bit_b;
  logic [3:0] word_a, word_b;
  logic       load_en_a, par_err_a, busy_a;
  logic       load_en_b, par_err_b, busy_b;
  logic [1:0] state_a, state_b;

  int n_tests = 0;
  int n_fail  = 0;

  logic [4:0] exp_a_q[$];
  logic [4:0] exp_b_q[$];
  logic [3:0] last_a = 4'h0;
  logic [3:0] last_b = 4'h0;

  logic       mon_on = 1'b0;
  logic       rst_seen;
  logic [3:0] prev_word_a = 4'h0, prev_word_b = 4'h0;
  logic       prev_pulse_a = 1'b0, prev_pulse_b = 1'b0;

  serial_word_assembler #(.WIDTH(4), .PARITY_EN(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bit_vld(vld_a), .sof(sof_a), .bit_in(bit_a),
    .word_out(word_a), .load_en(load_en_a), .par_err(par_err_a),
    .busy(busy_a), .state_dbg(state_a)
  );

  serial_word_assembler #(.WIDTH(4), .PARITY_EN(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bit_vld(vld_b), .sof(sof_b), .bit_in(bit_b),
    .word_out(word_b), .load_en(load_en_b), .par_err(par_err_b),
    .busy(busy_b), .state_dbg(state_b)
  );

  // ---------------- clock / reset bookkeeping ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rst_seen <= !rst_n;

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic set_in(input bit to_b, input logic v, input logic s, input logic b);
    vld_a = !to_b & v; sof_a = !to_b & s; bit_a = !to_b & b;
    vld_b =  to_b & v; sof_b =  to_b & s; bit_b =  to_b & b;
  endtask

  task automatic drive(input bit to_b, input logic s, input logic b);
    @(negedge clk);
    set_in(to_b, 1'b1, s, b);
  endtask

  task automatic idle_cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      set_in(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  // Full frame on dut_a; gap_max>0 inserts 1..gap_max idle cycles after each data bit.
  task automatic send_frame_a(input logic [3:0] d, input logic p, input int gap_max);
    logic good;
    for (int i = 3; i >= 0; i--) begin
      drive(1'b0, i == 3, d[i]);
      if (gap_max > 0) begin
        idle_cyc($urandom_range(1, gap_max));
        chk("a_gap_busy", busy_a, 1);
        chk("a_gap_no_pulse", {load_en_a, par_err_a}, 0);
      end
    end
    drive(1'b0, 1'b0, p);
    good = ((^d) ^ p) == 1'b0;
    exp_a_q.push_back({!good, good ? d : last_a});
    if (good) last_a = d;
    idle_cyc(1);
    chk("a_load_lat", load_en_a, good);
    chk("a_perr_lat", par_err_a, !good);
    idle_cyc(1);
    chk("a_busy_after", busy_a, 0);
    chk("a_pulse_one_cycle", {load_en_a, par_err_a}, 0);
  endtask

  task automatic send_frame_b(input logic [3:0] d);
    for (int i = 3; i >= 0; i--) drive(1'b1, i == 3, d[i]);
    exp_b_q.push_back({1'b0, d});
    last_b = d;
    idle_cyc(1);
    chk("b_load_lat", load_en_b, 1);
    idle_cyc(1);
    chk("b_busy_after", busy_b, 0);
  endtask

  // ---------------- monitors / scoreboard ----------------
  always @(negedge clk) begin
    if (mon_on) begin
      logic [4:0] e;
      if (load_en_a || par_err_a) begin
        if (exp_a_q.size() == 0) begin
          chk("a_unexpected_pulse", {load_en_a, par_err_a}, 0);
        end else begin
          e = exp_a_q.pop_front();
          chk("a_pulse_kind", par_err_a, e[4]);
          chk("a_word", word_a, e[3:0]);
        end
        chk("a_exclusive", load_en_a & par_err_a, 0);
        chk("a_no_double_pulse", prev_pulse_a, 0);
      end
      if (!load_en_a && !rst_seen) chk("a_word_hold", word_a, prev_word_a);
      prev_word_a  = word_a;
      prev_pulse_a = load_en_a | par_err_a;
    end
  end

  always @(negedge clk) begin
    if (mon_on) begin
      logic [4:0] e;
      if (par_err_b) chk("b_par_err_never", par_err_b, 0);
      if (load_en_b) begin
        if (exp_b_q.size() == 0) begin
          chk("b_unexpected_pulse", load_en_b, 0);
        end else begin
          e = exp_b_q.pop_front();
          chk("b_word", word_b, e[3:0]);
        end
        chk("b_no_double_pulse", prev_pulse_b, 0);
      end
      if (!load_en_b && !rst_seen) chk("b_word_hold", word_b, prev_word_b);
      prev_word_b  = word_b;
      prev_pulse_b = load_en_b;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_word_a", word_a, 0);
    chk("rst_pulses_a", {load_en_a, par_err_a}, 0);
    chk("rst_busy_a", busy_a, 0);
    chk("rst_word_b", word_b, 0);
    chk("rst_busy_b", busy_b, 0);
    rst_n = 1'b1;
    mon_on = 1'b1;

    // No parity: 1010 then sof in the LOAD cycle starting 0101.
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    exp_b_q.push_back({1'b0, 4'hA});
    exp_b_q.push_back({1'b0, 4'h5});
    @(negedge clk);
    chk("b_b2b_first_pulse", load_en_b, 1);
    chk("b_b2b_first_word", word_b, 4'hA);
    set_in(1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1);
    idle_cyc(1);
    chk("b_b2b_second_pulse", load_en_b, 1);
    chk("b_b2b_second_word", word_b, 4'h5);
    idle_cyc(1);
    chk("b_b2b_busy_after", busy_b, 0);
    last_b = 4'h5;

    // Parity: good frame, bad-parity frame, gapped frame.
    send_frame_a(4'hB, 1'b1, 0);
    chk("a_t1_word", word_a, 4'hB);
    send_frame_a(4'hB, 1'b0, 0);
    send_frame_a(4'hB, 1'b1, 3);

    // Restart in SHIFT: sof,1,1 then a full frame 0011 parity 0.
    drive(1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    send_frame_a(4'h3, 1'b0, 0);
    chk("a_t4_word", word_a, 4'h3);

    // Restart in PARITY: sof lands where the parity bit would go.
    drive(1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    send_frame_a(4'h6, 1'b0, 0);

    // Reset mid-frame, then bits without sof are ignored.
    drive(1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("a_rst_busy", busy_a, 0);
    chk("a_rst_word", word_a, 0);
    chk("b_rst_word", word_b, 0);
    last_a = 4'h0;
    last_b = 4'h0;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'(i));
    idle_cyc(2);
    chk("a_nosof_busy", busy_a, 0);
    chk("a_nosof_word", word_a, 0);

    // Random frames on both instances.
    for (int i = 0; i < 8; i++) begin
      logic [3:0] d;
      logic       p;
      d = 4'($urandom_range(0, 15));
      p = (^d) ^ ($urandom_range(0, 3) == 0);
      send_frame_a(d, p, $urandom_range(0, 2));
      send_frame_b(4'($urandom_range(0, 15)));
    end
    chk("a_final_word", word_a, last_a);
    chk("b_final_word", word_b, last_b);

    idle_cyc(3);
    chk("a_queue_drained", exp_a_q.size(), 0);
    chk("b_queue_drained", exp_b_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
